// File: rtl/norm_share_arbiter.sv
// -----------------------------------------------------------------------------
// norm_share_arbiter
//
// Two requesters share a single leading-one-detect / normalize datapath.
// The arbiter accepts one operand at a time. It spends one cycle computing
// (CALC) and then presents the registered result (HOLD) until the consumer
// takes it. While the result is being handed off, the next operand can be
// accepted in the same cycle. This gives one result every two cycles.
//
// Leading-one detection looks only at bits X_LEN-2:0 (72:0 by default).
// The top bit is carried through the shift, but it never counts as the
// leading one. An operand whose detect field is all zero reports the
// maximum shift and raises out_allzero_o.
//
// Configuration macro:
//   NORM_ARB_FIXED_PRIO_EN - when defined, req0 wins every tie and the
//                            round-robin pointer is removed. When it is
//                            undefined, ties alternate round-robin.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o        requester handshake (N = 0, 1)
//   reqN_data_i   [X_LEN-1:0]          unnormalized mantissa
//   out_valid_o / out_ready_i          result handshake
//   out_data_o    [X_LEN-1:0]          normalized mantissa
//   out_shift_o   [SHIFT_W-1:0]        leading-zero shift count
//   out_allzero_o                      detect field of the operand was zero
//   out_src_o                          requester that supplied the operand
// -----------------------------------------------------------------------------
module norm_share_arbiter #(
  parameter int X_LEN   = 74,
  parameter int SHIFT_W = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [X_LEN-1:0]   req0_data_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [X_LEN-1:0]   req1_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [X_LEN-1:0]   out_data_o,
  output logic [SHIFT_W-1:0] out_shift_o,
  output logic               out_allzero_o,
  output logic               out_src_o
);

  // Highest bit that takes part in leading-one detection; also the max shift.
  localparam int                 DET_MSB   = X_LEN - 2;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(DET_MSB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;

  // Clears in reset and sets on the first edge after release. No operand is
  // accepted until it is set, and both readies stay low while reset is held.
  logic               armed_q, armed_d;

  // Captured operand and its source id.
  logic [X_LEN-1:0]   opnd_q, opnd_d;
  logic               src_q, src_d;

  // Result registers. They load on the CALC->HOLD edge and stay frozen
  // through HOLD.
  logic [X_LEN-1:0]   res_data_q, res_data_d;
  logic [SHIFT_W-1:0] res_shift_q, res_shift_d;
  logic               res_allzero_q, res_allzero_d;
  logic               res_src_q, res_src_d;

  // Handshake / arbitration terms.
  logic               grant_c;      // 0: req0 wins, 1: req1 wins
  logic               any_valid_c;
  logic               slot_open_c;  // datapath can take an operand this cycle
  logic               accept_c;

  // Normalizer terms.
  logic [SHIFT_W-1:0] lod_idx_c;
  logic               lod_found_c;
  logic [SHIFT_W-1:0] shift_c;
  logic [X_LEN-1:0]   norm_c;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef NORM_ARB_FIXED_PRIO_EN
  // req1 is granted only when req0 is not asking.
  always_comb begin
    grant_c = req1_valid_i & ~req0_valid_i;
  end
`else
  // last_q holds the requester granted on the most recent accept. It resets
  // to 1, so the first tie after reset goes to req0.
  logic last_q, last_d;

  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      grant_c = ~last_q;
    end else begin
      grant_c = req1_valid_i;
    end
  end

  // The pointer only moves when an operand is actually taken.
  always_comb begin
    last_d = last_q;
    if (accept_c) begin
      last_d = grant_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // A hand-off can be refilled in the same cycle.
        if (out_ready_i) begin
          state_d = accept_c ? ST_CALC : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_open_c = 1'b0;
    if (armed_q) begin
      case (state_q)
        ST_IDLE: slot_open_c = 1'b1;
        ST_HOLD: slot_open_c = out_ready_i;
        default: slot_open_c = 1'b0;
      endcase
    end

    any_valid_c  = req0_valid_i | req1_valid_i;
    accept_c     = slot_open_c & any_valid_c;

    // Only the granted requester ever sees ready, so both readies are never
    // high together.
    req0_ready_o = slot_open_c & req0_valid_i & ~grant_c;
    req1_ready_o = slot_open_c & req1_valid_i &  grant_c;

    out_valid_o  = (state_q == ST_HOLD);
  end

  // ---------------------------------------------------------------------------
  // Leading-one detect and normalize on the captured operand
  // ---------------------------------------------------------------------------
  always_comb begin
    lod_idx_c   = '0;
    lod_found_c = 1'b0;
    // Scan upward so the last hit is the most significant set bit.
    for (int i = 0; i <= DET_MSB; i++) begin
      if (opnd_q[i]) begin
        lod_idx_c   = SHIFT_W'(i);
        lod_found_c = 1'b1;
      end
    end
    shift_c = lod_found_c ? (SHIFT_MAX - lod_idx_c) : SHIFT_MAX;
    // The top bit rides along and is shifted out when shift > 0.
    norm_c  = opnd_q << shift_c;
  end

  // ---------------------------------------------------------------------------
  // Operand capture and result load
  // ---------------------------------------------------------------------------
  always_comb begin
    opnd_d = opnd_q;
    src_d  = src_q;
    if (accept_c) begin
      opnd_d = grant_c ? req1_data_i : req0_data_i;
      src_d  = grant_c;
    end

    res_data_d    = res_data_q;
    res_shift_d   = res_shift_q;
    res_allzero_d = res_allzero_q;
    res_src_d     = res_src_q;
    if (state_q == ST_CALC) begin
      res_data_d    = norm_c;
      res_shift_d   = shift_c;
      res_allzero_d = ~lod_found_c;
      res_src_d     = src_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opnd_q        <= '0;
      src_q         <= 1'b0;
      res_data_q    <= '0;
      res_shift_q   <= '0;
      res_allzero_q <= 1'b0;
      res_src_q     <= 1'b0;
    end else begin
      opnd_q        <= opnd_d;
      src_q         <= src_d;
      res_data_q    <= res_data_d;
      res_shift_q   <= res_shift_d;
      res_allzero_q <= res_allzero_d;
      res_src_q     <= res_src_d;
    end
  end

  assign out_data_o    = res_data_q;
  assign out_shift_o   = res_shift_q;
  assign out_allzero_o = res_allzero_q;
  assign out_src_o     = res_src_q;

  // ---------------------------------------------------------------------------
  // Handshake properties
  // ---------------------------------------------------------------------------
  a_single_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req0_ready_o && req1_ready_o));

  a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=>
      (out_valid_o && $stable(out_data_o) && $stable(out_shift_o) &&
       $stable(out_allzero_o) && $stable(out_src_o)));

endmodule

// File: tb/tb_norm_share_arbiter.sv
`timescale 1ns/1ps
module tb_norm_share_arbiter;
  localparam int XL = 74;
  localparam int SW = 7;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [XL-1:0] req0_data_i, req1_data_i;
  logic          out_valid_o, out_ready_i;
  logic [XL-1:0] out_data_o;
  logic [SW-1:0] out_shift_o;
  logic          out_allzero_o, out_src_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [XL-1:0] data;
    logic [SW-1:0] shift;
    logic          az;
    logic          src;
  } res_t;

  norm_share_arbiter #(.X_LEN(XL), .SHIFT_W(SW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_data_i  (req0_data_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_data_i  (req1_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_shift_o  (out_shift_o),
    .out_allzero_o(out_allzero_o),
    .out_src_o    (out_src_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: count leading zeros of bits 72:0 from the top.
  function automatic res_t ref_norm(input logic [XL-1:0] d, input logic s);
    res_t r;
    int   lz;
    lz = 0;
    while (lz < XL-1 && d[XL-2-lz] == 1'b0) lz++;
    r.az    = (lz == XL-1);
    r.shift = r.az ? SW'(XL-2) : SW'(lz);
    r.data  = d << r.shift;
    r.src   = s;
    return r;
  endfunction

  function automatic logic [XL-1:0] rand_opnd();
    logic [95:0] r;
    int          k;
    k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k == 1) return {1'b1, {(XL-1){1'b0}}};
    r = {$urandom, $urandom, $urandom};
    r = r >> $urandom_range(0, 90);
    return r[XL-1:0];
  endfunction

  // Presents an operand until it is accepted. Returns at the window after the
  // accept edge, with the valid signal dropped.
  task automatic drive_accept(input logic which, input logic [XL-1:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      if (which) begin req1_valid_i = 1'b1; req1_data_i = d; end
      else       begin req0_valid_i = 1'b1; req0_data_i = d; end
      #1;
      if ((which ? req1_ready_o : req0_ready_o) === 1'b1) ok = 1'b1;
    end
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; out_ready_i = 1'b1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    req0_data_i = '1; req1_data_i = '1;
    @(negedge clk_i); @(negedge clk_i);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    total++; if (out_data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data_o); end
    total++; if (out_shift_o !== '0) begin bad++; $display("FAIL reset_shift got=%0d exp=0", out_shift_o); end
    total++; if (out_allzero_o !== 1'b0) begin bad++; $display("FAIL reset_allzero got=%b exp=0", out_allzero_o); end
    total++; if (out_src_o !== 1'b0) begin bad++; $display("FAIL reset_src got=%b exp=0", out_src_o); end
    total++; if ({req1_ready_o, req0_ready_o} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", req1_ready_o, req0_ready_o); end
    rst_ni = 1'b1;
    #1;
    total++; if ({req1_ready_o, req0_ready_o} !== 2'b00) begin bad++; $display("FAIL first_edge_idle got=%b%b exp=00", req1_ready_o, req0_ready_o); end
    @(negedge clk_i);
    total++; if ({req1_ready_o, req0_ready_o} !== 2'b01) begin bad++; $display("FAIL first_tie_req0 got=%b%b exp=01", req1_ready_o, req0_ready_o); end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
  endtask

  task automatic test_lod();
    logic [XL-1:0] d, ed;
    bit            ok;
    out_ready_i = 1'b1;
    // bit 72 set: no shift
    d = rand_opnd(); d[XL-2] = 1'b1;
    drive_accept(1'b0, d, ok);
    total++; if (!ok) begin bad++; $display("FAIL msb_accept got=timeout exp=accept"); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL msb_calc_valid got=%b exp=0", out_valid_o); end
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o} !== {1'b1, d, 7'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL msb_result got=%b/%h/%0d/%b/%b exp=1/%h/0/0/0", out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o, d);
    end
    @(negedge clk_i);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL msb_drain got=%b exp=0", out_valid_o); end
    // only bit 0 set, from req1: full shift
    d = 74'h1; ed = 74'h1 << 72;
    drive_accept(1'b1, d, ok);
    total++; if (!ok) begin bad++; $display("FAIL lsb_accept got=timeout exp=accept"); end
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o} !== {1'b1, ed, 7'd72, 1'b0, 1'b1}) begin
      bad++; $display("FAIL lsb_result got=%b/%h/%0d/%b/%b exp=1/%h/72/0/1", out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o, ed);
    end
    // zero operand
    d = '0;
    drive_accept(1'b0, d, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_accept got=timeout exp=accept"); end
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o} !== {1'b1, {XL{1'b0}}, 7'd72, 1'b1, 1'b0}) begin
      bad++; $display("FAIL zero_result got=%b/%h/%0d/%b/%b exp=1/0/72/1/0", out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_stall();
    logic [XL-1:0] d0, d1;
    res_t          e0, e1;
    bit            ok;
    d0 = rand_opnd(); d1 = rand_opnd();
    e0 = ref_norm(d0, 1'b0); e1 = ref_norm(d1, 1'b1);
    out_ready_i = 1'b0;
    drive_accept(1'b0, d0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_accept got=timeout exp=accept"); end
    req1_valid_i = 1'b1; req1_data_i = d1;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk_i);
      total++;
      if ({out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o} !== {1'b1, e0}) begin
        bad++; $display("FAIL stall_hold w=%0d got=%b/%h/%0d exp=1/%h/%0d", w, out_valid_o, out_data_o, out_shift_o, e0.data, e0.shift);
      end
      total++; if ({req1_ready_o, req0_ready_o} !== 2'b00) begin bad++; $display("FAIL stall_ready w=%0d got=%b%b exp=00", w, req1_ready_o, req0_ready_o); end
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    #1;
    total++; if ({req1_ready_o, req0_ready_o} !== 2'b10) begin bad++; $display("FAIL stall_refill got=%b%b exp=10", req1_ready_o, req0_ready_o); end
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL stall_single_xfer got=%b exp=0", out_valid_o); end
    @(negedge clk_i);
    total++;
    if ({out_valid_o, out_data_o, out_shift_o, out_allzero_o, out_src_o} !== {1'b1, e1}) begin
      bad++; $display("FAIL stall_next got=%b/%h/%0d/%b exp=1/%h/%0d/1", out_valid_o, out_data_o, out_shift_o, out_src_o, e1.data, e1.shift);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready_i = 1'b1;
    drive_accept(1'b0, rand_opnd(), ok);
    total++; if (!ok) begin bad++; $display("FAIL rstcalc_accept got=timeout exp=accept"); end
    rst_ni = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rstcalc_valid got=%b exp=0", out_valid_o); end
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk_i);
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rstcalc_ghost w=%0d got=%b exp=0", w, out_valid_o); end
    end
    // reset while a result is being held
    out_ready_i = 1'b0;
    drive_accept(1'b1, {1'b0, 1'b1, 72'd5}, ok);
    total++; if (!ok) begin bad++; $display("FAIL rsthold_accept got=timeout exp=accept"); end
    @(negedge clk_i);
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL rsthold_pre got=%b exp=1", out_valid_o); end
    rst_ni = 1'b0;
    #1;
    total++; if ({out_valid_o, out_data_o, out_src_o} !== {1'b1 ^ 1'b1, {XL{1'b0}}, 1'b0}) begin
      bad++; $display("FAIL rsthold_clear got=%b/%h/%b exp=0/0/0", out_valid_o, out_data_o, out_src_o);
    end
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk_i);
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rsthold_ghost w=%0d got=%b exp=0", w, out_valid_o); end
    end
  endtask

  task automatic test_back_to_back();
    int   nres;
    logic exp_src;
    nres = 0;
    out_ready_i = 1'b1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk_i);
      if (out_valid_o === 1'b1) begin
`ifdef NORM_ARB_FIXED_PRIO_EN
        exp_src = 1'b0;
`else
        exp_src = nres[0];
`endif
        total++; if (out_src_o !== exp_src) begin bad++; $display("FAIL b2b_src n=%0d got=%b exp=%b", nres, out_src_o, exp_src); end
        nres++;
      end
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      req0_data_i = rand_opnd(); req1_data_i = rand_opnd();
    end
    total++; if (nres != 9) begin bad++; $display("FAIL b2b_rate got=%0d exp=9", nres); end
    @(negedge clk_i);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  // Transaction-level model: an accepted operand becomes visible two windows
  // later and stays until the consumer takes it; a new operand is taken when
  // nothing is pending or the pending result is leaving.
  task automatic test_random(input int n, input int p0, input int p1, input int pr);
    res_t          q[$];
    int            due[$];
    logic          last, exp_v, v0, v1, g, avail, er0, er1, drain;
    logic [XL-1:0] d0, d1;
    int            t;
    @(negedge clk_i);
    rst_ni = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    last = 1'b1; t = 0;
    for (int it = 0; it < n + 12; it++) begin
      @(negedge clk_i);
      t++;
      exp_v = 1'b0;
      if (q.size() > 0) exp_v = (t >= due[0]);
      total++;
      if (out_valid_o !== exp_v) begin
        bad++; $display("FAIL rand_valid t=%0d got=%b exp=%b", t, out_valid_o, exp_v);
      end else if (exp_v) begin
        total++;
        if ({out_data_o, out_shift_o, out_allzero_o, out_src_o} !== q[0]) begin
          bad++; $display("FAIL rand_result t=%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", t,
                          out_data_o, out_shift_o, out_allzero_o, out_src_o, q[0].data, q[0].shift, q[0].az, q[0].src);
        end
      end
      drain = (it >= n);
      v0 = !drain && ($urandom_range(0, 99) < p0);
      v1 = !drain && ($urandom_range(0, 99) < p1);
      d0 = rand_opnd(); d1 = rand_opnd();
      req0_valid_i = v0; req0_data_i = d0;
      req1_valid_i = v1; req1_data_i = d1;
      out_ready_i  = drain || ($urandom_range(0, 99) < pr);
      #1;
      avail = (q.size() == 0) || (exp_v && out_ready_i);
`ifdef NORM_ARB_FIXED_PRIO_EN
      if (v0 && v1) g = 1'b0; else g = v1;
`else
      if (v0 && v1) g = ~last; else g = v1;
`endif
      er0 = avail && v0 && !g;
      er1 = avail && v1 && g;
      total++;
      if ({req1_ready_o, req0_ready_o} !== {er1, er0}) begin
        bad++; $display("FAIL rand_ready t=%0d got=%b%b exp=%b%b", t, req1_ready_o, req0_ready_o, er1, er0);
      end
      if (exp_v && out_ready_i) begin
        void'(q.pop_front());
        void'(due.pop_front());
      end
      if (er0 || er1) begin
        q.push_back(ref_norm(g ? d1 : d0, g));
        due.push_back(t + 2);
        last = g;
      end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d exp=0", q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_lod();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random(300, 50, 50, 60);
    test_random(300, 90, 90, 100);
    test_random(200, 30, 70, 30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
